// File: rtl/ub_pkg.sv
// rtl/ub_pkg.sv - shared constants and read FSM state type for unified_buffer_stream
package ub_pkg;
   localparam int UB_ADDRESSSIZE = 10;
   localparam int UB_WORDSIZE    = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } ub_state_e;
endpackage

// File: rtl/ub_skid_fifo.sv
// rtl/ub_skid_fifo.sv - 2-entry registered skid buffer between SRAM read stage and output stream
module ub_skid_fifo
   import ub_pkg::*;
#(
   parameter int W = UB_WORDSIZE + 1
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         s_tvalid,
   input  logic [W-1:0] s_tdata,
   output logic         m_tvalid,
   input  logic         m_tready,
   output logic [W-1:0] m_tdata,
   output logic [1:0]   count
);
   logic [W-1:0] slot0_q, slot1_q;
   logic [1:0]   count_q;
   logic         pop;

   assign pop      = m_tready && (count_q != 2'd0);
   assign m_tvalid = (count_q != 2'd0);
   assign m_tdata  = slot0_q;
   assign count    = count_q;

   // The writer never pushes into a full buffer, so a push always has a slot.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slot0_q <= '0;
         slot1_q <= '0;
         count_q <= 2'd0;
      end else begin
         case ({s_tvalid, pop})
            2'b10: begin
               if (count_q == 2'd0) slot0_q <= s_tdata;
               else                 slot1_q <= s_tdata;
               count_q <= count_q + 2'd1;
            end
            2'b01: begin
               slot0_q <= slot1_q;
               count_q <= count_q - 2'd1;
            end
            2'b11: begin
               if (count_q == 2'd1) begin
                  slot0_q <= s_tdata;
               end else begin
                  slot0_q <= slot1_q;
                  slot1_q <= s_tdata;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/unified_buffer_stream.sv
// rtl/unified_buffer_stream.sv - SRAM buffer with host write port and burst read stream; UB_PARITY_EN adds per-word parity
module unified_buffer_stream
   import ub_pkg::*;
#(
   parameter int ADDRESSSIZE = UB_ADDRESSSIZE,
   parameter int WORDSIZE    = UB_WORDSIZE
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   wr_en,
   input  logic [ADDRESSSIZE-1:0] wr_addr,
   input  logic [WORDSIZE-1:0]    wr_data,
   input  logic                   rd_start,
   input  logic [ADDRESSSIZE-1:0] rd_base,
   input  logic [ADDRESSSIZE:0]   rd_len,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WORDSIZE-1:0]    out_data,
   output logic                   out_last,
   output logic                   busy,
   output logic                   done
`ifdef UB_PARITY_EN
   ,
   output logic                   par_err
`endif
);
   localparam int DEPTH = 2 ** ADDRESSSIZE;
   localparam logic [ADDRESSSIZE:0] DEPTH_L = {1'b1, {ADDRESSSIZE{1'b0}}};
   localparam logic [ADDRESSSIZE:0] LEN_ONE = {{ADDRESSSIZE{1'b0}}, 1'b1};

   logic [WORDSIZE-1:0]    mem [DEPTH];
   logic [WORDSIZE-1:0]    rdata_q;
   ub_state_e              state_q;
   logic [ADDRESSSIZE-1:0] rd_addr_q, rd_addr_d;
   logic [ADDRESSSIZE:0]   iss_left_q, out_left_q, len_clamped;
   logic                   pend_q, pend_last_q, busy_q, done_q;
   logic                   accept, rd_issue, last_issue, can_issue, pop;
   logic                   fifo_valid;
   logic [1:0]             fifo_count;
   logic [WORDSIZE:0]      fifo_data;
   logic [2:0]             occ;

   assign accept      = (state_q == IDLE) && rd_start;
   assign len_clamped = (rd_len > DEPTH_L) ? DEPTH_L : rd_len;
   assign pop         = fifo_valid && out_ready;
   // Count the word in flight from the SRAM so the skid buffer can never overflow.
   assign occ         = {1'b0, fifo_count} + {2'b00, pend_q};
   assign can_issue   = (occ - {2'b00, pop}) < 3'd2;

   always_comb begin
      rd_issue   = 1'b0;
      rd_addr_d  = rd_addr_q;
      last_issue = (iss_left_q == LEN_ONE);
      if (accept && (len_clamped != '0)) begin
         rd_issue   = 1'b1;
         rd_addr_d  = rd_base;
         last_issue = (len_clamped == LEN_ONE);
      end else if ((state_q == READ) && can_issue) begin
         rd_issue   = 1'b1;
      end
   end

   // Write and read in one block so a same-address collision returns the old word.
   always_ff @(posedge clk) begin
      if (wr_en)    mem[wr_addr] <= wr_data;
      if (rd_issue) rdata_q <= mem[rd_addr_d];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         rd_addr_q   <= '0;
         iss_left_q  <= '0;
         out_left_q  <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         pend_q      <= rd_issue;
         pend_last_q <= rd_issue && last_issue;
         done_q      <= 1'b0;
         if (rd_issue) rd_addr_q <= rd_addr_d + 1'b1;
         case (state_q)
            IDLE: if (rd_start) begin
               if (len_clamped == '0) begin
                  done_q <= 1'b1;
               end else begin
                  busy_q     <= 1'b1;
                  iss_left_q <= len_clamped - LEN_ONE;
                  out_left_q <= len_clamped;
                  state_q    <= (len_clamped == LEN_ONE) ? DRAIN : READ;
               end
            end
            READ: if (rd_issue) begin
               iss_left_q <= iss_left_q - LEN_ONE;
               if (iss_left_q == LEN_ONE) state_q <= DRAIN;
            end
            default: ;
         endcase
         if ((state_q != IDLE) && pop) begin
            out_left_q <= out_left_q - LEN_ONE;
            if (out_left_q == LEN_ONE) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
         end
      end
   end

   ub_skid_fifo #(.W(WORDSIZE + 1)) u_skid (
      .clk      (clk),
      .rstn     (rstn),
      .s_tvalid (pend_q),
      .s_tdata  ({pend_last_q, rdata_q}),
      .m_tvalid (fifo_valid),
      .m_tready (out_ready),
      .m_tdata  (fifo_data),
      .count    (fifo_count)
   );

   assign out_valid = fifo_valid;
   assign out_data  = fifo_data[WORDSIZE-1:0];
   assign out_last  = fifo_valid && fifo_data[WORDSIZE];
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef UB_PARITY_EN
   logic par_mem [DEPTH];
   logic rpar_q, par_err_q;

   always_ff @(posedge clk) begin
      if (wr_en)    par_mem[wr_addr] <= ^wr_data;
      if (rd_issue) rpar_q <= par_mem[rd_addr_d];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                 par_err_q <= 1'b0;
      else if (pend_q && ((^rdata_q) != rpar_q)) par_err_q <= 1'b1;
   end

   assign par_err = par_err_q;
`endif
endmodule

// File: doc/unified_buffer_stream.md
UNIFIED_BUFFER_STREAM -- requirements
Module: unified_buffer_stream

Interface
REQ-001 SHALL have parameter ADDRESSSIZE, default 10, address bits; depth = 2**ADDRESSSIZE words.
REQ-002 SHALL have parameter WORDSIZE, default 64, data bits per word.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports wr_en  input  1, wr_addr  input  ADDRESSSIZE and wr_data  input  WORDSIZE, forming the host write port.
REQ-006 SHALL have ports rd_start  input  1, rd_base  input  ADDRESSSIZE and rd_len  input  ADDRESSSIZE+1, forming the burst request.
REQ-007 SHALL have ports out_valid  output  1, out_ready  input  1, out_data  output  WORDSIZE and out_last  output  1, forming the stream to the array.
REQ-008 SHALL have ports busy  output  1 (burst in progress) and done  output  1 (one-cycle burst-complete pulse).
REQ-009 SHALL have port par_err  output  1, sticky parity error, present only under UB_PARITY_EN.

Function
REQ-010 SHALL write wr_data to mem[wr_addr] on the clock edge when wr_en=1, whether busy is high or low.
REQ-011 SHALL implement the read FSM with states IDLE, READ and DRAIN.
REQ-012 SHALL, in IDLE, accept rd_start=1 by latching rd_base and rd_len and raising busy the next cycle; rd_start while busy SHALL be ignored.
REQ-013 SHALL, for rd_start with rd_len=0, return to IDLE without emitting beats and pulse done one cycle after acceptance.
REQ-014 SHALL use a synchronous 1-cycle SRAM read; with out_ready held high, the first out_valid SHALL assert 2 cycles after the rd_start cycle.
REQ-015 SHALL issue reads only while the skid buffer has a free slot; under continuous out_ready, throughput SHALL be 1 word/cycle.
REQ-016 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-017 SHALL increment the read address modulo depth, so a burst of base=depth-1, len=2 reads depth-1 then 0.
REQ-018 SHALL enforce rd_len <= depth; larger values SHALL be clamped to depth.
REQ-019 SHALL assert out_last with the final beat only.
REQ-020 SHALL move to DRAIN after issuing the last read, and to IDLE on the last handshake; busy SHALL fall and done SHALL pulse in the cycle after that handshake.
REQ-021 SHALL, when a read and a write hit the same address in the same cycle, return the old (pre-write) data.

Reset
REQ-022 SHALL, while rstn=0, force out_valid, out_last, busy, done and par_err to 0, set the FSM to IDLE and empty the skid buffer.
REQ-023 SHALL NOT clear memory contents on reset.
REQ-024 SHALL abort a burst in progress when rstn is asserted mid-burst, with no done pulse.

Configuration
REQ-025 SHALL, with UB_PARITY_EN defined, store one even-parity bit per word, check it on every read and set par_err sticky until reset on any mismatch; data SHALL still be delivered.
REQ-026 SHALL, without UB_PARITY_EN, omit the parity storage and the par_err port.

Structure
REQ-027 SHALL place the FSM state enum (IDLE, READ, DRAIN) and the default ADDRESSSIZE/WORDSIZE constants in shared package ub_pkg.
REQ-028 SHALL implement the 2-entry output skid buffer as sub-module ub_skid_fifo, parametrised by WORDSIZE+1 (data plus last).

Verification
REQ-029 SHALL cover: write mem[i]=i*0x0101010101010101 for i=0..15; burst base=0, len=16, out_ready=1 -> 16 consecutive beats, first 2 cycles after rd_start, out_last on beat 15, done one cycle later.
REQ-030 SHALL cover: burst base=4, len=8, out_ready toggling 1/0 each cycle -> exactly 8 beats with values mem[4..11], no duplicates or drops, data stable during stalls.
REQ-031 SHALL cover: ADDRESSSIZE=4, burst base=14, len=4 -> beats mem[14], mem[15], mem[0], mem[1].
REQ-032 SHALL cover: rd_len=0 -> no out_valid and a done pulse; a second rd_start while busy -> ignored, with the first burst unaffected.
REQ-033 SHALL cover: rstn pulled low at beat 3 of len=16 -> outputs 0 immediately, no done; a subsequent burst completes normally and memory is intact.
REQ-034 SHALL cover, under UB_PARITY_EN: a forced parity bit flip on word 5 -> par_err rises after beat 5 is read and stays high until reset.
